mem_port_arbiter: RTL and testbench

Shares one single-ported, handshaked memory between the core's instruction-fetch port and its load/store port. It sequences the core by driving its `i_clk_en`: it freezes the pipeline, serves the data access of the instruction in E, then fetches the instruction for F, then releases exactly one pipeline step. It sits between `Core` and the unified RAM/ROM mapper, and replaces the separate instruction-ROM and data-memory ports.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 15 +
 rtl/mem_port_arbiter_store_lane_align.sv | 28 ++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding, instruction constants and width helpers for the memory port arbiter.
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_DATA  = 2'd0,
    S_FETCH = 2'd1,
    S_STEP  = 2'd2
  } arb_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int xlen_w(input int xlen);
    return 1 << (xlen + 4);
  endfunction

  function automatic int xlen_nb(input int xlen);
    return xlen_w(xlen) / 8;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshaked request/ack bus between the arbiter and the unified RAM/ROM mapper.
interface mem_port_arbiter_if #(
  parameter int W = 64
);
  logic           req;
  logic           we;
  logic [W-1:0]   addr;
  logic [W-1:0]   wdata;
  logic [W/8-1:0] be;
  logic [W-1:0]   rdata;
  logic           ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/mem_port_arbiter_store_lane_align.sv
// Places right-aligned store data onto its byte lanes and builds the matching byte enables.
module store_lane_align #(
  parameter  int W  = 64,
  localparam int NB = W / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0] i_offset,
  input  logic          i_byte,
  input  logic          i_half,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_wdata,
  output logic [NB-1:0] o_be
);

  assign o_wdata = i_data << {i_offset, 3'b000};

  // Lanes shifted past the top of the word simply fall off.
  always_comb begin
    if (i_byte) begin
      o_be = {{(NB-1){1'b0}}, 1'b1} << i_offset;
    end else if (i_half) begin
      o_be = {{(NB-2){1'b0}}, 2'b11} << i_offset;
    end else begin
      o_be = '1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Time-multiplexes one memory port between data access and instruction fetch,
// stepping the frozen core once per completed data+fetch pair.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int XLEN = `XLEN_64b,
  localparam int W    = xlen_w(XLEN),
  localparam int NB   = xlen_nb(XLEN)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_clk_en,
  input  logic [W-1:0]       i_fetch_addr_f,
  input  logic               i_lw_e,
  input  logic               i_sw_e,
  input  logic [W-1:0]       i_mem_addr_e,
  input  logic [W-1:0]       i_mem_data_e,
  input  logic               i_store_byte_e,
  input  logic               i_store_half_e,
  input  logic               i_bad_addr_f,
  input  logic               i_bad_addr_load_e,
  input  logic               i_bad_addr_store_e,
  output logic [31:0]        o_instr_f,
  output logic [W-1:0]       o_mem_data_m,
  mem_port_arbiter_if.master ram
);

  localparam int OW = $clog2(NB);

  arb_state_e  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [W-1:0] load_e_q, load_e_d;
  logic [W-1:0] mem_data_m_q, mem_data_m_d;

  logic          data_need;
  logic [W-1:0]  st_wdata;
  logic [NB-1:0] st_be;

  assign data_need = (i_lw_e & ~i_bad_addr_load_e) | (i_sw_e & ~i_bad_addr_store_e);

  store_lane_align #(.W(W)) u_store_lane_align (
    .i_offset (i_mem_addr_e[OW-1:0]),
    .i_byte   (i_store_byte_e),
    .i_half   (i_store_half_e),
    .i_data   (i_mem_data_e),
    .o_wdata  (st_wdata),
    .o_be     (st_be)
  );

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    load_e_d     = load_e_q;
    mem_data_m_d = mem_data_m_q;
    o_clk_en     = 1'b0;
    ram.req      = 1'b0;
    ram.we       = 1'b0;
    ram.addr     = '0;
    ram.wdata    = '0;
    ram.be       = '0;
    unique case (state_q)
      S_DATA: begin
        if (data_need) begin
          ram.req  = 1'b1;
          ram.we   = i_sw_e;
          ram.addr = i_mem_addr_e;
          if (i_sw_e) begin
            ram.wdata = st_wdata;
            ram.be    = st_be;
          end else begin
            ram.be = '1;
          end
          if (ram.ack) begin
            if (!i_sw_e) load_e_d = ram.rdata;
            state_d = S_FETCH;
          end
        end else begin
          load_e_d = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!i_bad_addr_f) begin
          ram.req  = 1'b1;
          ram.addr = i_fetch_addr_f;
          if (ram.ack) begin
            instr_d = ram.rdata[31:0];
            state_d = S_STEP;
          end
        end else begin
          // Faulting fetch: the core's exception logic reports it, we just feed a NOP.
          instr_d = NOP_INSTR;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        o_clk_en     = 1'b1;
        mem_data_m_d = load_e_q;
        state_d      = S_DATA;
      end
      default: state_d = S_DATA;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_DATA;
      instr_q      <= NOP_INSTR;
      load_e_q     <= '0;
      mem_data_m_q <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      load_e_q     <= load_e_d;
      mem_data_m_q <= mem_data_m_d;
    end
  end

  assign o_instr_f    = instr_q;
  assign o_mem_data_m = mem_data_m_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: the driver pushes expected requests/steps from a step-level model, a monitor pops and compares.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        clk_en;
  logic [63:0] fetch_addr, maddr, mdata;
  logic        lw, sw, sb, sh, bad_f, bad_ld, bad_st;
  logic [31:0] instr;
  logic [63:0] mem_m;

  mem_port_arbiter_if #(.W(64)) ram_if ();

  mem_port_arbiter dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .o_clk_en           (clk_en),
    .i_fetch_addr_f     (fetch_addr),
    .i_lw_e             (lw),
    .i_sw_e             (sw),
    .i_mem_addr_e       (maddr),
    .i_mem_data_e       (mdata),
    .i_store_byte_e     (sb),
    .i_store_half_e     (sh),
    .i_bad_addr_f       (bad_f),
    .i_bad_addr_load_e  (bad_ld),
    .i_bad_addr_store_e (bad_st),
    .o_instr_f          (instr),
    .o_mem_data_m       (mem_m),
    .ram                (ram_if)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [7:0]  be;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] mem_m;
  } step_exp_t;

  typedef struct {
    bit          lw, sw, sb, sh, bad_f, bad_ld, bad_st;
    logic [63:0] faddr, maddr, mdata;
    int          dly;
  } stim_t;

  req_t      exp_req[$];
  step_exp_t exp_step[$];
  int        n_checks = 0;
  int        n_fail = 0;
  int        delay_ovr = -1;
  bit        late_ack = 0;
  logic [63:0] model_load_e = '0;

  function automatic logic [63:0] mem_f(input logic [63:0] a);
    if (a == 64'h18) return 64'hDEAD_BEEF_CAFE_F00D;
    return {a[31:0] ^ 32'hA5A5_0F0F, a[31:0] + 32'h1357_9BDF};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: random wait states, plus stray acks while no request is pending.
  int wait_left = 0;
  bit in_req = 0;
  initial begin
    ram_if.ack   = 1'b0;
    ram_if.rdata = '0;
    forever begin
      @(negedge clk);
      if (ram_if.req === 1'b1 && !rst) begin
        if (!in_req) begin
          in_req = 1;
          wait_left = (delay_ovr >= 0) ? delay_ovr :
                      (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        if (wait_left == 0) begin
          ram_if.ack   = 1'b1;
          ram_if.rdata = mem_f(ram_if.addr);
          in_req = 0;
        end else begin
          ram_if.ack   = 1'b0;
          ram_if.rdata = {$urandom, $urandom};
          wait_left--;
        end
      end else begin
        in_req = 0;
        ram_if.ack   = late_ack || ($urandom_range(0, 3) == 0);
        ram_if.rdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor: compares every request cycle and every step pulse against the queues.
  int cyc = 0, waits = 0;
  bit prev_en = 0;
  step_exp_t se;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        exp_req.delete();
        exp_step.delete();
        cyc = 0; waits = 0; prev_en = 0;
      end else begin
        cyc++;
        if (ram_if.req === 1'b1) begin
          if (ram_if.ack !== 1'b1) waits++;
          if (exp_req.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL req_unexpected: got addr %h we %b expected no request", ram_if.addr, ram_if.we);
          end else begin
            chk("req_we", 64'(ram_if.we), 64'(exp_req[0].we));
            chk("req_addr", ram_if.addr, exp_req[0].addr);
            chk("req_wdata", ram_if.wdata, exp_req[0].wd);
            chk("req_be", 64'(ram_if.be), 64'(exp_req[0].be));
            if (ram_if.ack === 1'b1) void'(exp_req.pop_front());
          end
        end
        if (clk_en === 1'b1) begin
          chk("clk_en_back_to_back", 64'(prev_en), 64'(0));
          chk("req_during_step", 64'(ram_if.req), 64'(0));
          chk("step_period", 64'(cyc), 64'(3 + waits));
          if (exp_step.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL step_unexpected: got clk_en pulse expected none");
          end else begin
            se = exp_step.pop_front();
            chk("instr_f", 64'(instr), 64'(se.instr));
            chk("mem_data_m", mem_m, se.mem_m);
          end
          cyc = 0; waits = 0;
        end
        prev_en = clk_en;
      end
    end
  end

  task automatic apply(input stim_t s);
    req_t r;
    step_exp_t e;
    logic [2:0] off;
    logic [63:0] fw;
    bit need;
    lw = s.lw; sw = s.sw; sb = s.sb; sh = s.sh;
    bad_f = s.bad_f; bad_ld = s.bad_ld; bad_st = s.bad_st;
    fetch_addr = s.faddr; maddr = s.maddr; mdata = s.mdata;
    delay_ovr = s.dly;
    need = (s.lw && !s.bad_ld) || (s.sw && !s.bad_st);
    e.mem_m = model_load_e;
    if (need) begin
      off = s.maddr[2:0];
      r.we = s.sw;
      r.addr = s.maddr;
      if (s.sw) begin
        r.wd = s.mdata << (8 * off);
        r.be = s.sb ? 8'(1 << off) : (s.sh ? 8'(3 << off) : 8'hFF);
      end else begin
        r.wd = '0;
        r.be = 8'hFF;
        model_load_e = mem_f(s.maddr);
      end
      exp_req.push_back(r);
    end else begin
      model_load_e = '0;
    end
    if (!s.bad_f) begin
      r.we = 1'b0; r.addr = s.faddr; r.wd = '0; r.be = '0;
      exp_req.push_back(r);
    end
    fw = mem_f(s.faddr);
    e.instr = s.bad_f ? NOP_INSTR : fw[31:0];
    exp_step.push_back(e);
  endtask

  task automatic wait_pulse();
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (clk_en === 1'b1) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL step_timeout: got no clk_en in 60 cycles expected a pulse");
    end
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle(input logic [63:0] fa, input int d);
    stim_t s;
    s = '{default: 0};
    s.faddr = fa;
    s.dly = d;
    return s;
  endfunction

  stim_t s;
  initial begin
    rst = 1'b1;
    lw = 0; sw = 0; sb = 0; sh = 0; bad_f = 0; bad_ld = 0; bad_st = 0;
    fetch_addr = '0; maddr = '0; mdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_clk_en", 64'(clk_en), 64'(0));
    chk("rst_req", 64'(ram_if.req), 64'(0));
    chk("rst_we", 64'(ram_if.we), 64'(0));
    chk("rst_addr", ram_if.addr, 64'(0));
    chk("rst_be", 64'(ram_if.be), 64'(0));
    chk("rst_instr", 64'(instr), 64'(NOP_INSTR));
    chk("rst_mem_m", mem_m, 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      apply(idle(64'h100 + 64'(4 * i), 0));
      wait_pulse();
    end
    s = idle(64'h10C, 0); s.lw = 1; s.maddr = 64'h18;
    apply(s); wait_pulse();
    s = idle(64'h110, 0); s.sw = 1; s.sb = 1; s.maddr = 64'h2005; s.mdata = 64'hAB;
    apply(s); wait_pulse();
    apply(idle(64'h114, 4)); wait_pulse();
    s = idle(64'h118, -1); s.sw = 1; s.bad_st = 1; s.maddr = 64'h30; s.mdata = 64'h55;
    apply(s); wait_pulse();
    s = idle(64'h11C, -1); s.bad_f = 1;
    apply(s); wait_pulse();

    for (int i = 0; i < 200; i++) begin
      int kind, sz;
      s = idle({32'h0, $urandom}, -1);
      kind = int'($urandom_range(0, 3));
      sz = int'($urandom_range(0, 2));
      s.lw = (kind == 1);
      s.sw = (kind == 2);
      s.sb = (sz == 0);
      s.sh = (sz == 1);
      s.maddr = {32'h0, $urandom};
      s.mdata = {$urandom, $urandom};
      s.bad_f = ($urandom_range(0, 7) == 0);
      s.bad_ld = ($urandom_range(0, 7) == 0);
      s.bad_st = ($urandom_range(0, 7) == 0);
      apply(s);
      wait_pulse();
    end

    // Reset while a load is stalled waiting for its ack.
    s = idle(64'h1F0, 1000); s.lw = 1; s.maddr = 64'h40;
    apply(s);
    repeat (3) @(negedge clk);
    chk("stall_req", 64'(ram_if.req), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    lw = 0; sw = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    late_ack = 1;
    model_load_e = '0;
    apply(idle(64'h200, -1));
    @(negedge clk);
    chk("rst_mid_req", 64'(ram_if.req), 64'(0));
    chk("rst_mid_clk_en", 64'(clk_en), 64'(0));
    chk("rst_mid_instr", 64'(instr), 64'(NOP_INSTR));
    chk("rst_mid_mem_m", mem_m, 64'(0));
    @(posedge clk);
    #1;
    late_ack = 0;
    wait_pulse();
    for (int i = 0; i < 3; i++) begin
      apply(idle(64'h204 + 64'(4 * i), -1));
      wait_pulse();
    end
    chk("leftover_req", 64'(exp_req.size()), 64'(0));
    chk("leftover_step", 64'(exp_step.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500us");
    $fatal(1, "watchdog");
  end

endmodule
